// File: rtl/inv_zz_pkg.sv
// Shared constants and the zigzag-scan-position to raster-address table.
package inv_zz_pkg;
    localparam int BLK_SIZE = 64;
    localparam int ADDR_W   = 6;

    localparam logic [ADDR_W-1:0] ZZ_TAB [BLK_SIZE] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    function automatic logic [ADDR_W-1:0] zz2raster(input logic [ADDR_W-1:0] k);
        return ZZ_TAB[k];
    endfunction
endpackage

// File: rtl/inv_zz_bank_ram.sv
// Two-bank simple dual-port RAM with a registered read port.
module inv_zz_bank_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 6
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic                  wr_bank,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  rd_bank,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [2*(1<<ADDR_W)];

    always_ff @(posedge clk) begin
        if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
        if (rd_en) rd_data <= mem[{rd_bank, rd_addr}];
    end
endmodule

// File: rtl/inverse_zigzag.sv
// Zigzag-to-raster reorder for 8x8 coefficient blocks using a ping-pong
// bank pair; one bank fills while the other drains through a 2-entry skid.
module inverse_zigzag
    import inv_zz_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  err_framing
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLK_SIZE - 1);

    logic [1:0]            bank_full;
    logic                  wr_sel, rd_sel;
    logic [ADDR_W-1:0]     wr_cnt, rd_cnt;
    logic                  wr_fire, wr_end, rd_issue, rd_end, pop;
    logic                  rd_vld, rd_last;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] skid_data [2];
    logic [1:0]            skid_last;
    logic [1:0]            occ, occ_kept;

    assign in_ready = ~rst & ~bank_full[wr_sel];
    assign wr_fire  = in_valid & in_ready;
    assign wr_end   = wr_fire & (wr_cnt == LAST_ADDR);
    assign pop      = out_valid & out_ready;

    // Count the entry leaving this cycle as free so a word can be issued
    // every cycle while the consumer keeps up.
    assign occ_kept = occ - {1'b0, pop};
    assign rd_issue = bank_full[rd_sel] & ((occ_kept + {1'b0, rd_vld}) < 2'd2);
    assign rd_end   = rd_issue & (rd_cnt == LAST_ADDR);

    assign out_valid = (occ != 2'd0);
    assign out_data  = skid_data[0];
    assign out_last  = skid_last[0];

    inv_zz_bank_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .wr_en   (wr_fire),
        .wr_bank (wr_sel),
        .wr_addr (zz2raster(wr_cnt)),
        .wr_data (in_data),
        .rd_en   (rd_issue),
        .rd_bank (rd_sel),
        .rd_addr (rd_cnt),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_full   <= 2'b00;
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            err_framing <= 1'b0;
            rd_vld      <= 1'b0;
            rd_last     <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
                // in_last never realigns the counter; it only flags disagreement
                if (in_last != (wr_cnt == LAST_ADDR)) err_framing <= 1'b1;
            end
            if (wr_end) begin
                bank_full[wr_sel] <= 1'b1;
                wr_sel            <= ~wr_sel;
            end
            if (rd_issue) rd_cnt <= rd_cnt + 1'b1;
            if (rd_end) begin
                bank_full[rd_sel] <= 1'b0;
                rd_sel            <= ~rd_sel;
            end
            rd_vld  <= rd_issue;
            rd_last <= rd_end;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ          <= 2'd0;
            skid_data[0] <= '0;
            skid_data[1] <= '0;
            skid_last    <= 2'b00;
        end else begin
            if (pop) begin
                skid_data[0] <= skid_data[1];
                skid_last[0] <= skid_last[1];
            end
            if (rd_vld) begin
                if (occ_kept == 2'd0) begin
                    skid_data[0] <= rd_data;
                    skid_last[0] <= rd_last;
                end else begin
                    skid_data[1] <= rd_data;
                    skid_last[1] <= rd_last;
                end
            end
            occ <= occ_kept + {1'b0, rd_vld};
        end
    end
endmodule

// File: tb/tb_inverse_zigzag.sv
// Randomised bench for inverse_zigzag; reference order is derived by walking
// the 8x8 anti-diagonals directly.
module tb_inverse_zigzag;
    localparam int DW = 32;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_last = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          err_framing;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int stall_cnt = 0;
    int out_cnt = 0;
    int last_acc_cyc = 0;
    int first_valid_cyc = -1;
    int rdy_mode = 0;
    int inv_tab [64];
    exp_t exp_q [$];
    logic [DW-1:0] cap [$];
    exp_t e;
    logic hold = 1'b0;
    logic [DW-1:0] hold_data = '0;
    int base;

    inverse_zigzag #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_last     (in_last),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .err_framing (err_framing)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // inv_tab[raster] = zigzag scan position, even diagonals run upward
    function automatic void build_inv();
        int n = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            for (int i = 0; i <= hi - lo; i++) begin
                int row = (s % 2 == 0) ? hi - i : lo + i;
                inv_tab[row*8 + (s - row)] = n;
                n++;
            end
        end
    endfunction

    task automatic send_blocks(input int nblk, input bit ramp, input int vpct,
                               input int last_pos, input int stop_after);
        logic [DW-1:0] blk [64];
        for (int b = 0; b < nblk; b++) begin
            int k = 0;
            int guard = 0;
            for (int i = 0; i < 64; i++) blk[i] = ramp ? DW'(i) : DW'($urandom);
            while (k < stop_after && guard < 5000) begin
                @(negedge clk);
                in_valid = ($urandom_range(99) < vpct);
                in_data  = blk[k];
                in_last  = (k == last_pos);
                #1;
                guard++;
                if (in_valid && !in_ready) stall_cnt++;
                if (in_valid && in_ready) begin
                    acc_cnt++;
                    last_acc_cyc = cyc;
                    k++;
                    if (k == 64)
                        for (int r = 0; r < 64; r++)
                            exp_q.push_back('{data: blk[inv_tab[r]], last: (r == 63)});
                end
            end
            if (guard >= 5000) chk("drv_timeout", k, stop_after);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int g = 0;
        while ((exp_q.size() != 0 || out_valid) && g < bound) begin
            @(negedge clk); #2;
            g++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk); #3;
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_err", err_framing, 0);
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk); #2;
        chk("post_rst_ready", in_ready, 1);
    endtask

    // consumer + scoreboard
    initial begin
        forever begin
            @(negedge clk);
            out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
            #1;
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", out_data, hold_data);
                end
                if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_valid", out_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data", out_data, e.data);
                        chk("last", out_last, e.last);
                    end
                    cap.push_back(out_data);
                    out_cnt++;
                end
                hold = out_valid && !out_ready;
                hold_data = out_data;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        build_inv();
        do_reset();

        // 1: single ramp block, latency and known raster order
        rdy_mode = 0;
        cap.delete();
        first_valid_cyc = -1;
        send_blocks(1, 1'b1, 100, 63, 64);
        wait_drain(500);
        chk("t1_latency", first_valid_cyc - last_acc_cyc, 3);
        chk("t1_count", cap.size(), 64);
        if (cap.size() == 64) begin
            chk("t1_out0", cap[0], 0);
            chk("t1_out2", cap[2], 5);
            chk("t1_out3", cap[3], 6);
            chk("t1_out8", cap[8], 2);
            chk("t1_out63", cap[63], 63);
        end
        chk("t1_err", err_framing, 0);

        // 2: four back-to-back blocks, no input stall
        base = out_cnt;
        stall_cnt = 0;
        send_blocks(4, 1'b0, 100, 63, 64);
        chk("t2_stalls", stall_cnt, 0);
        wait_drain(500);
        chk("t2_outputs", out_cnt - base, 256);

        // 3: output held off, both banks fill
        do_reset();
        rdy_mode = 2;
        base = acc_cnt;
        fork
            send_blocks(3, 1'b0, 100, 63, 64);
            begin
                repeat (200) @(negedge clk);
                #2;
                chk("t3_accepted", acc_cnt - base, 128);
                chk("t3_in_ready", in_ready, 0);
                rdy_mode = 0;
            end
        join
        wait_drain(800);

        // 4: random handshakes on both sides
        rdy_mode = 1;
        base = out_cnt;
        send_blocks(20, 1'b0, 50, 63, 64);
        wait_drain(3000);
        chk("t4_outputs", out_cnt - base, 1280);
        rdy_mode = 0;

        // 5: early in_last
        do_reset();
        base = acc_cnt;
        fork
            send_blocks(1, 1'b1, 100, 40, 64);
            begin
                int g = 0;
                while (acc_cnt != base + 41 && g < 500) begin
                    @(negedge clk); #2;
                    g++;
                end
                chk("t5_reach41", acc_cnt - base, 41);
                chk("t5_err_before", err_framing, 0);
                @(negedge clk); #2;
                chk("t5_err_rise", err_framing, 1);
            end
        join
        wait_drain(500);
        chk("t5_err_sticky", err_framing, 1);
        do_reset();

        // 6: reset mid-block, then mid-drain
        base = out_cnt;
        send_blocks(1, 1'b0, 100, 63, 30);
        do_reset();
        repeat (100) @(negedge clk);
        chk("t6_idle_a", out_cnt - base, 0);
        rdy_mode = 2;
        send_blocks(1, 1'b0, 100, 63, 64);
        begin
            int g = 0;
            while (!out_valid && g < 50) begin
                @(negedge clk); #2;
                g++;
            end
            chk("t6_drain_seen", out_valid, 1);
        end
        do_reset();
        rdy_mode = 0;
        base = out_cnt;
        repeat (100) @(negedge clk);
        chk("t6_idle_b", out_cnt - base, 0);
        send_blocks(1, 1'b0, 100, 63, 64);
        wait_drain(500);
        chk("t6_fresh", out_cnt - base, 64);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
